// File: rtl/seg_pkg.sv
// Seven-segment capture constants shared by the decoder and its lookup.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low patterns (0 = lit), bit0=a .. bit5=f, bit6=g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational pattern-to-BCD lookup; flags legal digits and the blank pattern.
module seg_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] value,
    output logic       legal,
    output logic       blank
);

    // Table lookup; anything not listed is illegal with value forced to 0
    always_comb begin
        value = 4'd0;
        legal = 1'b1;
        blank = 1'b0;
        case (seg_n)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_capture_decoder.sv
// Captures a multiplexed 4-digit seven-segment display and decodes it to BCD.
// A digit is accepted after its (an_n, seg_n) pair has been stable for
// STABLE_CYCLES registered cycles; long idle periods invalidate the capture.
module seg_capture_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                seg_n,
    input  logic [3:0]                an_n,
    output logic [NUM_DIGITS*4-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic [NUM_DIGITS-1:0]     digit_err,
    output logic                      frame_valid
);

    localparam int DW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(STABLE_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

    logic [3:0]            an_q, an_p;
    logic [6:0]            seg_q, seg_p;
    logic [DW-1:0]         dwell_cnt, dwell_nx;
    logic [IW-1:0]         idle_cnt, idle_nx;
    logic [NUM_DIGITS-1:0] seen, seen_upd, seen_nx;
    logic [NUM_DIGITS-1:0] an_sel;
    logic                  sel_valid, pair_same, commit, timeout;
    logic [3:0]            value;
    logic                  legal, blank;
    logic [NUM_DIGITS*4-1:0] digits_nx;
    logic [NUM_DIGITS-1:0] valid_nx, err_nx;
    logic                  frame_nx;

    // Single input register stage plus a copy of the previous registered pair
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= 4'hF;
            seg_q <= SEG_BLANK;
            an_p  <= 4'hF;
            seg_p <= SEG_BLANK;
        end else begin
            an_q  <= an_n;
            seg_q <= seg_n;
            an_p  <= an_q;
            seg_p <= seg_q;
        end
    end

    // Exactly one low enable is a selection; anything else counts as idle
    assign an_sel    = ~an_q;
    assign sel_valid = (an_sel != 4'd0) && ((an_sel & (an_sel - 4'd1)) == 4'd0);
    assign pair_same = ({an_q, seg_q} == {an_p, seg_p});

    seg_to_bcd u_lut (
        .seg_n (seg_q),
        .value (value),
        .legal (legal),
        .blank (blank)
    );

    // Dwell and idle counter next-state; commit fires only on the first arrival at the limit
    always_comb begin
        if (!sel_valid)
            dwell_nx = '0;
        else if (!pair_same)
            dwell_nx = DW'(1);
        else if (dwell_cnt == DWELL_MAX)
            dwell_nx = DWELL_MAX;
        else
            dwell_nx = dwell_cnt + DW'(1);

        if (sel_valid)
            idle_nx = '0;
        else if (idle_cnt == IDLE_MAX)
            idle_nx = IDLE_MAX;
        else
            idle_nx = idle_cnt + IW'(1);
    end

    assign commit   = sel_valid && (dwell_nx == DWELL_MAX) && (dwell_cnt != DWELL_MAX);
    assign timeout  = !sel_valid && (idle_nx == IDLE_MAX);
    assign seen_upd = seen | an_sel;

    // Output and seen-mask next-state for a commit or a timeout (never both)
    always_comb begin
        digits_nx = digits;
        valid_nx  = digit_valid;
        err_nx    = digit_err;
        seen_nx   = seen;
        frame_nx  = 1'b0;
        if (timeout) begin
            valid_nx = '0;
            err_nx   = '0;
            seen_nx  = '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (an_sel[i]) begin
                    if (legal)
                        digits_nx[4*i +: 4] = value;
                    valid_nx[i] = legal;
                    err_nx[i]   = ~legal & ~blank;
                end
            end
            if (seen_upd == ALL_SEEN) begin
                seen_nx  = '0;
                frame_nx = (err_nx == '0) && (valid_nx == ALL_SEEN);
            end else begin
                seen_nx = seen_upd;
            end
        end
    end

    // Counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            dwell_cnt <= dwell_nx;
            idle_cnt  <= idle_nx;
        end
    end

    // Registered outputs and seen mask
    always_ff @(posedge clk) begin
        if (reset) begin
            digits      <= '0;
            digit_valid <= '0;
            digit_err   <= '0;
            seen        <= '0;
            frame_valid <= 1'b0;
        end else begin
            digits      <= digits_nx;
            digit_valid <= valid_nx;
            digit_err   <= err_nx;
            seen        <= seen_nx;
            frame_valid <= frame_nx;
        end
    end

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Bench for seg_capture_decoder: directed scenarios plus random scanning,
// every cycle compared against a history-window reference model.
module tb_seg_capture_decoder;

    localparam int S = 4;
    localparam int T = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  an_n = 4'hF;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_err;
    logic        frame_valid;

    always #5 clk = ~clk;

    seg_capture_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .digits      (digits),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int frames = 0;

    // Reference model: history of registered pin pairs (-1 marks a reset boundary)
    int         hist[$];
    logic [3:0] m_dig[4];
    logic [3:0] m_val, m_err, m_seen;
    logic       m_frame;
    logic [6:0] pat[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int get(input int k);
        if (k >= hist.size()) return -1;
        return hist[hist.size() - 1 - k];
    endfunction

    // Count of low enable bits equals one -> digit selected
    function automatic bit is_sel(input int code);
        int lows = 0;
        if (code < 0) return 1'b0;
        for (int b = 0; b < 4; b++)
            if (((code >> (7 + b)) & 1) == 0) lows++;
        return lows == 1;
    endfunction

    task automatic model_commit(input int code);
        int d = 0;
        int idx = -1;
        int s = code & 'h7F;
        for (int b = 0; b < 4; b++)
            if (((code >> (7 + b)) & 1) == 0) d = b;
        for (int v = 0; v < 10; v++)
            if (int'(pat[v]) == s) idx = v;
        m_seen[d] = 1'b1;
        if (idx >= 0) begin
            m_dig[d] = 4'(idx);
            m_val[d] = 1'b1;
            m_err[d] = 1'b0;
        end else begin
            m_val[d] = 1'b0;
            m_err[d] = (s != 'h7F);
        end
        if (m_seen == 4'hF) begin
            m_seen  = 4'h0;
            m_frame = (m_err == 4'h0) && (m_val == 4'hF);
        end
    endtask

    task automatic model_step();
        int cur;
        int run;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
            m_val = 0; m_err = 0; m_seen = 0; m_frame = 0;
            hist = '{-1, 'h7FF};
        end else begin
            cur = get(0);
            run = 0;
            m_frame = 1'b0;
            if (is_sel(cur)) begin
                while (run <= S && get(run) == cur) run++;
                if (run == S) model_commit(cur);
            end else begin
                while (run < T && get(run) >= 0 && !is_sel(get(run))) run++;
                if (run >= T) begin
                    m_val = 0; m_err = 0; m_seen = 0;
                end
            end
            hist.push_back(int'({an_n, seg_n}));
            if (hist.size() > T + 4) void'(hist.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (frame_valid === 1'b1) frames++;
        chk("digits", 32'(digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
        chk("digit_valid", 32'(digit_valid), 32'(m_val));
        chk("digit_err", 32'(digit_err), 32'(m_err));
        chk("frame_valid", 32'(frame_valid), 32'(m_frame));
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an_n  = a;
        seg_n = s;
        repeat (n) tick();
    endtask

    initial begin
        logic [3:0] a;
        logic [6:0] s;
        int r;

        // Reset state
        hist = '{-1};
        reset = 1'b1;
        tick();
        tick();
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_err", 32'(digit_err), 32'h0);
        chk("rst_frame", 32'(frame_valid), 32'h0);

        // Single held digit: visible from cycle 5, then stable
        reset = 1'b0;
        hold(4'hE, 7'h30, 4);
        chk("hold_c4_valid", 32'(digit_valid), 32'h0);
        tick();
        chk("hold_c5_valid", 32'(digit_valid), 32'h1);
        chk("hold_c5_digit", 32'(digits[3:0]), 32'h3);
        repeat (6) tick();
        chk("hold_later_digits", 32'(digits), 32'h0003);
        chk("hold_later_valid", 32'(digit_valid), 32'h1);

        // Full scan 1,2,3,4 -> one frame pulse
        frames = 0;
        hold(4'hE, 7'h79, 6);
        hold(4'hD, 7'h24, 6);
        hold(4'hB, 7'h30, 6);
        hold(4'h7, 7'h19, 6);
        chk("scan_digits", 32'(digits), 32'h4321);
        chk("scan_frames", 32'(frames), 32'd1);

        // Illegal pattern on digit 1, then a scan that completes the errored frame
        hold(4'hD, 7'h08, 6);
        chk("bad_err", 32'(digit_err), 32'h2);
        chk("bad_valid1", 32'(digit_valid[1]), 32'h0);
        chk("bad_digit1", 32'(digits[7:4]), 32'h2);
        frames = 0;
        hold(4'hB, 7'h30, 6);
        hold(4'h7, 7'h19, 6);
        hold(4'hE, 7'h79, 6);
        chk("bad_scan_frames", 32'(frames), 32'd0);
        hold(4'hD, 7'h24, 6);

        // Pattern toggling faster than the dwell, then a two-digit enable
        for (int k = 0; k < 6; k++) hold(4'hE, (k % 2 == 0) ? 7'h40 : 7'h02, 3);
        chk("toggle_digits", 32'(digits), 32'h4321);
        chk("toggle_valid", 32'(digit_valid), 32'hF);
        hold(4'hC, 7'h00, 10);
        chk("multi_digits", 32'(digits), 32'h4321);
        chk("multi_valid", 32'(digit_valid), 32'hF);

        // Valid frame 5,6,7,8, an error on digit 2, then a long idle
        frames = 0;
        hold(4'hE, 7'h12, 6);
        hold(4'hD, 7'h02, 6);
        hold(4'hB, 7'h78, 6);
        hold(4'h7, 7'h00, 6);
        chk("frame2_frames", 32'(frames), 32'd1);
        hold(4'hB, 7'h55, 6);
        chk("pre_idle_err", 32'(digit_err), 32'h4);
        hold(4'hF, 7'h7F, T + 2);
        chk("idle_valid", 32'(digit_valid), 32'h0);
        chk("idle_err", 32'(digit_err), 32'h0);
        chk("idle_digits", 32'(digits), 32'h8765);

        // Reset at dwell count 3 discards the dwell
        hold(4'hB, 7'h19, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rdw_first", 32'(digit_valid), 32'h0);
        repeat (4) tick();
        chk("rdw_c4_valid", 32'(digit_valid), 32'h0);
        tick();
        chk("rdw_c5_valid", 32'(digit_valid), 32'h4);
        chk("rdw_c5_digits", 32'(digits), 32'h0400);

        // Random scanning: legal, blank, garbage, idle enables, occasional reset
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 80) a = ~(4'b0001 << $urandom_range(0, 3));
            else        a = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 99);
            if (r < 70)      s = pat[$urandom_range(0, 9)];
            else if (r < 85) s = 7'h7F;
            else             s = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 99) < 2) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            hold(a, s, $urandom_range(1, 8));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seg_capture_decoder.md
SEG_CAPTURE_DECODER -- requirements
Module: seg_capture_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the consecutive-cycle dwell needed to accept a digit (legal range 2..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, is the number of idle cycles before captured state is invalidated (legal range 2..65535).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 seg_n  in  7  segment lines, active-low (0 = lit); bit0=a … bit5=f, bit6=g.
REQ-006 an_n  in  4  digit enables, active-low; bit i low selects digit i.
REQ-007 digits  out  16  decoded BCD; digit i occupies bits [4i+3:4i].
REQ-008 digit_valid  out  4  bit i set when digit i holds a legally decoded value.
REQ-009 digit_err  out  4  bit i set when the last capture of digit i was an illegal pattern.
REQ-010 frame_valid  out  1  one-cycle pulse when a complete, error-free 4-digit frame has been captured.

Function
REQ-011 seg_n and an_n shall pass through exactly one input register stage before any other use.
REQ-012 A selection is valid only when exactly one an_n bit is low; an_n=4'hF or more than one low bit is "idle".
REQ-013 The dwell counter shall reset to 1 when the registered (an_n, seg_n) pair differs from the previous cycle, or to 0 when idle, and shall otherwise increment, saturating at STABLE_CYCLES.
REQ-014 A commit shall occur exactly once per dwell, on the cycle the counter first reaches STABLE_CYCLES; a longer dwell shall not re-commit.
REQ-015 Decode table (seg_n -> value): 7'h40->0, 7'h79->1, 7'h24->2, 7'h30->3, 7'h19->4, 7'h12->5, 7'h02->6, 7'h78->7, 7'h00->8, 7'h10->9.
REQ-016 On a commit with a legal pattern: digits slot i is updated, digit_valid[i]=1, digit_err[i]=0.
REQ-017 On a commit with blank pattern 7'h7F: digits slot i is unchanged, digit_valid[i]=0, digit_err[i]=0.
REQ-018 On a commit with any other pattern: digits slot i is unchanged, digit_valid[i]=0, digit_err[i]=1.
REQ-019 Latency: with a valid pair held at the pins from cycle 0, the commit results shall be visible on the outputs from cycle STABLE_CYCLES+1.
REQ-020 An internal seen mask shall set bit i on every commit to digit i, whatever the pattern.
REQ-021 When a commit makes the seen mask 4'hF, the seen mask shall clear; frame_valid shall pulse in the same cycle the commit becomes visible, but only if digit_err==0 and digit_valid==4'hF after that commit.
REQ-022 The idle counter shall increment on each idle cycle, saturating at TIMEOUT_CYCLES, and shall clear on any valid selection.
REQ-023 When the idle counter reaches TIMEOUT_CYCLES, digit_valid, digit_err and the seen mask shall clear; digits shall be retained.
REQ-024 A commit and a timeout cannot coincide; no priority rule is required.

Reset
REQ-025 While reset is asserted: digits=0, digit_valid=0, digit_err=0, frame_valid=0, seen mask=0, both counters=0, and input registers load an_n=4'hF, seg_n=7'h7F.
REQ-026 Reset asserted mid-dwell shall discard the dwell; capture restarts from the first post-reset cycle.

Structure
REQ-027 Package seg_pkg shall hold the ten legal pattern constants, SEG_BLANK=7'h7F, and NUM_DIGITS=4.
REQ-028 The pattern-to-value lookup shall be a separate combinational sub-module, seg_to_bcd (in: seg_n[6:0]; out: value[3:0], legal, blank).
REQ-029 All remaining logic shall be in seg_capture_decoder, with no latches.

Verification
REQ-030 After reset, hold an_n=4'hE, seg_n=7'h30 -> digits[3:0]=3 and digit_valid=4'b0001 from cycle 5; no further change while held.
REQ-031 Scan digits 0..3 with patterns 7'h79, 7'h24, 7'h30, 7'h19, 6 cycles each -> digits=16'h4321 and a single frame_valid pulse on the digit-3 commit.
REQ-032 Hold an_n=4'hD, seg_n=7'h08 for 6 cycles -> digit_err=4'b0010, digit_valid[1]=0, digits[7:4] unchanged; a subsequent full scan -> no frame_valid.
REQ-033 Toggle seg_n every 3 cycles on digit 0 (STABLE_CYCLES=4), and separately drive an_n=4'hC -> no commit and outputs unchanged in both cases.
REQ-034 After a valid frame, drive an_n=4'hF for 1024 cycles -> digit_valid=0 and digit_err=0 at that point, digits retained.
REQ-035 Assert reset for one cycle at dwell count 3 -> no commit; the digit commits 4 cycles after the first post-reset cycle, with outputs visible from the following cycle.
